serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_digit.sv | 18 +
 rtl/serial_sub.sv | 107 ++++++++++
 tb/tb_serial_sub.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A legal configuration splits WIDTH into a whole number of DIGIT-bit slices.
    function automatic bit cfg_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// One DIGIT-bit slice of a ripple subtractor: d = x - y - bi, bo = borrow out.
module digit_sub #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] r;

    // The extra top bit goes negative exactly when the slice needs a borrow.
    assign r       = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
    assign {bo, d} = r;

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: a - b - bin, one DIGIT-bit slice per cycle, LSB first.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = cnt_bits(NSLICE);

    state_t           state, nstate;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic             brw;
    logic [DIGIT-1:0] sd;
    logic             sbo;
    logic             last;

    digit_sub #(.DIGIT(DIGIT)) u_digit (
        .x  (sa[DIGIT-1:0]),
        .y  (sb[DIGIT-1:0]),
        .bi (brw),
        .d  (sd),
        .bo (sbo)
    );

    assign last    = (cnt == CW'(NSLICE - 1));
    // New slice enters at the top so the LSB slice ends up at bit 0 after NSLICE shifts.
    assign sr_next = (sr >> DIGIT) | (WIDTH'(sd) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> DIGIT;
                    sb  <= sb >> DIGIT;
                    sr  <= sr_next;
                    brw <= sbo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        // On the last slice sa/sb hold the operand MSBs in their top digit bit.
                        diff <= sr_next;
                        bout <= sbo;
                        ovf  <= (sa[DIGIT-1] != sb[DIGIT-1]) && (sd[DIGIT-1] != sa[DIGIT-1]);
                        zero <= (sr_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized, model-checked bench for serial_sub at 8/1, plus 16/4 and an exhaustive 4/1 sweep.
module tb_serial_sub;

    localparam int N0 = 8;
    localparam int N1 = 4;
    localparam int N2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 0, bin0 = 0;
    logic [7:0]  a0 = 0, b0 = 0;
    logic        busy0, done0, bout0, ovf0, zero0;
    logic [7:0]  diff0;

    logic        start1 = 0, bin1 = 0;
    logic [15:0] a1 = 0, b1 = 0;
    logic        busy1, done1, bout1, ovf1, zero1;
    logic [15:0] diff1;

    logic        start2 = 0, bin2 = 0;
    logic [3:0]  a2 = 0, b2 = 0;
    logic        busy2, done2, bout2, ovf2, zero2;
    logic [3:0]  diff2;

    serial_sub #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .bin(bin0),
        .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .ovf(ovf0), .zero(zero0));

    serial_sub #(.WIDTH(16), .DIGIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1), .zero(zero1));

    serial_sub #(.WIDTH(4), .DIGIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2), .zero(zero2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic ref_sub(input int w, input int ua, input int ub, input int ubi,
                           output int rd, output bit rbo, output bit rov);
        int m, sa, sb, r;
        m   = 1 << w;
        r   = ua - ub - ubi;
        rbo = (r < 0);
        rd  = (r + m) % m;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        r   = sa - sb - ubi;
        rov = (r < -(m / 2)) || (r >= m / 2);
    endtask

    // Reference for the 4-bit sweep: chained 1-bit full-subtractor truth table.
    function automatic logic [4:0] fs_chain(input logic [3:0] x, input logic [3:0] y, input logic bi);
        logic       br;
        logic [3:0] d;
        br = bi;
        for (int i = 0; i < 4; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    // Timing model for dut0: phase 0 idle, 1..N0 running, N0+1 result cycle.
    int         ph = 0;
    int         p_diff = 0;
    bit         p_bout = 0, p_ovf = 0;
    logic [7:0] m_diff = 0;
    logic       m_bout = 0, m_ovf = 0, m_zero = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; m_diff = 0; m_bout = 0; m_ovf = 0; m_zero = 1;
        end else if (ph == 0) begin
            if (start0) begin
                ref_sub(8, int'(a0), int'(b0), int'(bin0), p_diff, p_bout, p_ovf);
                ph = 1;
            end
        end else if (ph == N0) begin
            ph     = N0 + 1;
            m_diff = 8'(p_diff);
            m_bout = p_bout;
            m_ovf  = p_ovf;
            m_zero = (p_diff == 0);
        end else if (ph == N0 + 1) begin
            ph = 0;
        end else begin
            ph++;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy0), 32'(ph != 0));
        check("done", 32'(done0), 32'(ph == N0 + 1));
        check("diff", 32'(diff0), 32'(m_diff));
        check("bout", 32'(bout0), 32'(m_bout));
        check("ovf",  32'(ovf0),  32'(m_ovf));
        check("zero", 32'(zero0), 32'(m_zero));
    end

    // Call at a negedge; returns edge index (accepting edge = 1) of first done and done count.
    task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input int pulse_at, output int lat, output int ndone);
        a0 = a; b0 = b; bin0 = bi; start0 = 1;
        lat = -1; ndone = 0;
        for (int k = 1; k <= N0 + 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) start0 = 0;
            if (k == pulse_at) start0 = 1;
            else if (k == pulse_at + 1) start0 = 0;
            if (done0) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic wait_done0(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (done0) begin k = i; break; end
        end
    endtask

    int lat, nd, t;
    int rd;
    bit rbo, rov;
    logic [4:0] fs;

    initial begin
        #1 rst_n = 0;
        #1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_diff", 32'(diff0), 0);
        check("rst_zero", 32'(zero0), 1);
        check("rst_bout", 32'(bout0), 0);
        check("rst_ovf",  32'(ovf0),  0);
        @(negedge clk);
        rst_n = 1;

        op0(8'h05, 8'h03, 1'b0, 0, lat, nd);
        check("lat_basic", lat, N0 + 1);
        check("diff_05_03", 32'(diff0), 32'h02);
        check("bout_05_03", 32'(bout0), 0);
        check("ovf_05_03", 32'(ovf0), 0);
        check("zero_05_03", 32'(zero0), 0);

        op0(8'h10, 8'h0F, 1'b1, 3, lat, nd);
        check("lat_ignore", lat, N0 + 1);
        check("ndone_ignore", nd, 1);
        check("diff_10_0f", 32'(diff0), 0);
        check("zero_10_0f", 32'(zero0), 1);
        check("bout_10_0f", 32'(bout0), 0);

        // Held start: back-to-back operations, operands swapped between them.
        @(negedge clk);
        a0 = 8'h00; b0 = 8'h01; bin0 = 0; start0 = 1;
        wait_done0(N0 + 4, t);
        check("lat_b2b", t, N0 + 1);
        check("diff_00_01", 32'(diff0), 32'hFF);
        check("bout_00_01", 32'(bout0), 1);
        check("ovf_00_01", 32'(ovf0), 0);
        a0 = 8'h80; b0 = 8'h01;
        wait_done0(N0 + 6, t);
        check("period_b2b", t, N0 + 2);
        check("diff_80_01", 32'(diff0), 32'h7F);
        check("ovf_80_01", 32'(ovf0), 1);
        check("bout_80_01", 32'(bout0), 0);
        start0 = 0;
        repeat (2) @(posedge clk);

        // Abort mid-run.
        @(negedge clk);
        a0 = 8'h33; b0 = 8'h11; bin0 = 0; start0 = 1;
        @(posedge clk); #1 start0 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        check("abort_diff", 32'(diff0), 0);
        check("abort_zero", 32'(zero0), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        op0(8'h33, 8'h11, 1'b0, 0, lat, nd);
        check("lat_after_rst", lat, N0 + 1);
        check("diff_after_rst", 32'(diff0), 32'h22);

        // Random traffic: starts while busy, operand churn, occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst_n  = 1;
            start0 = 1'($urandom_range(0, 1));
            a0     = 8'($urandom);
            b0     = 8'($urandom);
            bin0   = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 0;
            end
        end
        @(negedge clk);
        rst_n = 1; start0 = 0;

        // 16-bit, 4-bit digits.
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h4321; bin1 = 0; start1 = 1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 0;
            if (done1 && lat < 0) lat = k;
        end
        check("lat_w16", lat, N1 + 1);
        check("diff_w16", 32'(diff1), 32'hCF13);
        check("bout_w16", 32'(bout1), 1);
        check("ovf_w16", 32'(ovf1), 0);
        check("zero_w16", 32'(zero1), 0);

        // Exhaustive 4-bit sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a2 = 4'(x); b2 = 4'(y); bin2 = 1'(c); start2 = 1;
                    lat = -1;
                    for (int k = 1; k <= N2 + 4; k++) begin
                        @(posedge clk); #1;
                        if (k == 1) start2 = 0;
                        if (done2) begin lat = k; break; end
                    end
                    fs = fs_chain(4'(x), 4'(y), 1'(c));
                    ref_sub(4, x, y, c, rd, rbo, rov);
                    check("w4_lat", lat, N2 + 1);
                    check("w4_diff", 32'(diff2), 32'(fs[3:0]));
                    check("w4_bout", 32'(bout2), 32'(fs[4]));
                    check("w4_ovf", 32'(ovf2), 32'(rov));
                    check("w4_zero", 32'(zero2), 32'(rd == 0));
                    @(posedge clk);
                end
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
